// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared FSM state type, default channel count and rank compare
package pic_pkg;

    localparam int PIC_NUM_IRQ = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_ACK
    } pic_state_e;

    // True when channel a outranks channel b; (lp+1) mod n is the top rank.
    function automatic logic higher_rank(input int a, input int b, input int lp, input int n);
        return ((a - lp - 1 + 2 * n) % n) < ((b - lp - 1 + 2 * n) % n);
    endfunction

endpackage

// File: rtl/rotate_priority_enc.sv
// rtl/rotate_priority_enc.sv - rotating find-first: first set bit scanning up from lp+1
module rotate_priority_enc
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = PIC_NUM_IRQ,
    parameter int IDW     = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req,
    input  logic [IDW-1:0]     lp,
    output logic               valid,
    output logic [IDW-1:0]     index
);

    always_comb begin
        valid = 1'b0;
        index = '0;
        // Scan from lowest rank to highest so the highest-ranked hit is written last.
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (req[(int'(lp) + 1 + k) % NUM_IRQ]) begin
                valid = 1'b1;
                index = IDW'((int'(lp) + 1 + k) % NUM_IRQ);
            end
        end
    end

endmodule

// File: rtl/priority_engine.sv
// rtl/priority_engine.sv - fully nested rotating-priority interrupt arbiter with INTA handshake
module priority_engine
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = PIC_NUM_IRQ,
    parameter int IDW     = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irr_masked,
    input  logic               inta,
    input  logic               eoi,
    input  logic               seoi,
    input  logic [IDW-1:0]     seoi_level,
    input  logic               set_prio,
    input  logic [IDW-1:0]     prio_level,
    input  logic               rotate_mode,
    input  logic               aeoi_mode,
    output logic               int_out,
    output logic [NUM_IRQ-1:0] isr,
    output logic [NUM_IRQ-1:0] irr_clr,
    output logic [IDW-1:0]     vector_id
);

    pic_state_e         r_state;
    logic               r_int_out;
    logic [NUM_IRQ-1:0] r_isr;
    logic [NUM_IRQ-1:0] r_irr_clr;
    logic [IDW-1:0]     r_vector_id;
    logic [IDW-1:0]     r_lp;

    logic               w_isr_valid;
    logic [IDW-1:0]     w_isr_top;
    logic [NUM_IRQ-1:0] w_qual;
    logic               w_win_valid;
    logic [IDW-1:0]     w_win;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_set;
    logic [IDW-1:0]     w_lp_next;

    function automatic logic [NUM_IRQ-1:0] onehot(input logic [IDW-1:0] idx);
        logic [NUM_IRQ-1:0] m;
        for (int i = 0; i < NUM_IRQ; i++) begin
            m[i] = (int'(idx) == i);
        end
        return m;
    endfunction

    rotate_priority_enc #(.NUM_IRQ(NUM_IRQ), .IDW(IDW)) u_isr_enc (
        .req   (r_isr),
        .lp    (r_lp),
        .valid (w_isr_valid),
        .index (w_isr_top)
    );

    always_comb begin
        w_qual = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_qual[i] = irr_masked[i] &&
                        (!w_isr_valid || higher_rank(i, int'(w_isr_top), int'(r_lp), NUM_IRQ));
        end
    end

    rotate_priority_enc #(.NUM_IRQ(NUM_IRQ), .IDW(IDW)) u_win_enc (
        .req   (w_qual),
        .lp    (r_lp),
        .valid (w_win_valid),
        .index (w_win)
    );

    // Later assignments win: AEOI < EOI < specific EOI < explicit priority set.
    always_comb begin
        w_clr     = '0;
        w_set     = '0;
        w_lp_next = r_lp;
        if (r_state == ST_ACK && inta && aeoi_mode) begin
            w_clr = w_clr | onehot(r_vector_id);
            if (rotate_mode) w_lp_next = r_vector_id;
        end
        if (eoi && !seoi && w_isr_valid) begin
            w_clr = w_clr | onehot(w_isr_top);
            if (rotate_mode) w_lp_next = w_isr_top;
        end
        if (seoi && int'(seoi_level) < NUM_IRQ) begin
            w_clr = w_clr | onehot(seoi_level);
            if (rotate_mode) w_lp_next = seoi_level;
        end
        if (set_prio && int'(prio_level) < NUM_IRQ) begin
            w_lp_next = prio_level;
        end
        if (r_state == ST_PEND && inta && w_win_valid) begin
            w_set = onehot(w_win);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_int_out   <= 1'b0;
            r_isr       <= '0;
            r_irr_clr   <= '0;
            r_vector_id <= '0;
            r_lp        <= IDW'(NUM_IRQ - 1);
        end else begin
            r_isr     <= (r_isr & ~w_clr) | w_set;
            r_irr_clr <= w_set;
            r_lp      <= w_lp_next;
            case (r_state)
                ST_IDLE: begin
                    if (w_win_valid) begin
                        r_state   <= ST_PEND;
                        r_int_out <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (inta) begin
                        r_state     <= ST_ACK;
                        r_int_out   <= 1'b0;
                        r_vector_id <= w_win_valid ? w_win : IDW'(NUM_IRQ - 1);
                    end else if (!w_win_valid) begin
                        r_state   <= ST_IDLE;
                        r_int_out <= 1'b0;
                    end
                end
                ST_ACK: begin
                    if (inta) r_state <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_int_out <= 1'b0;
                end
            endcase
        end
    end

    assign int_out   = r_int_out;
    assign isr       = r_isr;
    assign irr_clr   = r_irr_clr;
    assign vector_id = r_vector_id;

endmodule
